// File: rtl/t06_lcd1602_rx.sv
// HD44780-style 1602 LCD bus receiver: decodes instruction/data writes and
// mirrors the 2x16 visible character buffer onto two packed 128-bit rows.
module t06_lcd1602_rx #(
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         lcd_en,
    input  logic         lcd_rw,
    input  logic         lcd_rs,
    input  logic [7:0]   lcd_data,
    output logic [127:0] row_1,
    output logic [127:0] row_2,
    output logic [6:0]   ddram_addr,
    output logic         display_on,
    output logic         busy,
    output logic         wr_strobe,
    output logic         cmd_strobe,
    output logic         drop
);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    // Two-line DDRAM map: 0x00-0x27 and 0x40-0x67 form one 80-cell ring.
    function automatic logic [6:0] step_addr(input logic [6:0] addr, input logic up);
        logic [6:0] res;
        if (up) begin
            if (addr == 7'h27)      res = 7'h40;
            else if (addr == 7'h67) res = 7'h00;
            else                    res = addr + 7'd1;
        end else begin
            if (addr == 7'h00)      res = 7'h67;
            else if (addr == 7'h40) res = 7'h27;
            else                    res = addr - 7'd1;
        end
        return res;
    endfunction

    logic       en_q;
    logic       rs_q;
    logic       rw_q;
    logic [7:0] data_q;

    state_t     state_reg, state_next;
    logic [6:0] addr_reg, addr_next;
    logic       inc_reg, inc_next;
    logic       disp_reg, disp_next;
    logic [4:0] clr_idx_reg, clr_idx_next;
    logic       wr_strobe_reg, wr_strobe_next;
    logic       cmd_strobe_reg, cmd_strobe_next;
    logic       drop_reg, drop_next;

    logic [7:0] cell_reg [32];
    logic       cell_we;
    logic [4:0] cell_idx;
    logic [7:0] cell_val;

    logic       commit;

    assign commit = en_q & ~lcd_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q   <= 1'b0;
            rs_q   <= 1'b0;
            rw_q   <= 1'b0;
            data_q <= 8'h00;
        end else begin
            en_q   <= lcd_en;
            rs_q   <= lcd_rs;
            rw_q   <= lcd_rw;
            data_q <= lcd_data;
        end
    end

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        inc_next        = inc_reg;
        disp_next       = disp_reg;
        clr_idx_next    = clr_idx_reg;
        wr_strobe_next  = 1'b0;
        cmd_strobe_next = 1'b0;
        drop_next       = 1'b0;
        cell_we         = 1'b0;
        cell_idx        = 5'd0;
        cell_val        = BLANK_CHAR;

        case (state_reg)
            ST_CLEAR: begin
                cell_we      = 1'b1;
                cell_idx     = clr_idx_reg;
                cell_val     = BLANK_CHAR;
                clr_idx_next = clr_idx_reg + 5'd1;
                if (clr_idx_reg == 5'd31) begin
                    state_next = ST_IDLE;
                end
                // Reads are never honoured, so they are not counted as drops.
                if (commit && !rw_q) begin
                    drop_next = 1'b1;
                end
            end

            default: begin
                if (commit && !rw_q) begin
                    if (rs_q) begin
                        wr_strobe_next = 1'b1;
                        addr_next      = step_addr(addr_reg, inc_reg);
                        if (addr_reg[6:4] == 3'b000) begin
                            cell_we  = 1'b1;
                            cell_idx = {1'b0, addr_reg[3:0]};
                            cell_val = data_q;
                        end else if (addr_reg[6:4] == 3'b100) begin
                            cell_we  = 1'b1;
                            cell_idx = {1'b1, addr_reg[3:0]};
                            cell_val = data_q;
                        end
                    end else begin
                        casez (data_q)
                            8'b1???????: begin
                                cmd_strobe_next = 1'b1;
                                addr_next       = data_q[6:0];
                            end
                            8'b01??????,
                            8'b001?????: begin
                                cmd_strobe_next = 1'b1;
                            end
                            8'b0001????: begin
                                cmd_strobe_next = 1'b1;
                                if (!data_q[3]) begin
                                    addr_next = step_addr(addr_reg, data_q[2]);
                                end
                            end
                            8'b00001???: begin
                                cmd_strobe_next = 1'b1;
                                disp_next       = data_q[2];
                            end
                            8'b000001??: begin
                                cmd_strobe_next = 1'b1;
                                inc_next        = data_q[1];
                            end
                            8'b0000001?: begin
                                cmd_strobe_next = 1'b1;
                                addr_next       = 7'h00;
                            end
                            8'b00000001: begin
                                cmd_strobe_next = 1'b1;
                                addr_next       = 7'h00;
                                inc_next        = 1'b1;
                                clr_idx_next    = 5'd0;
                                state_next      = ST_CLEAR;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= 7'h00;
            inc_reg        <= 1'b1;
            disp_reg       <= 1'b0;
            clr_idx_reg    <= 5'd0;
            wr_strobe_reg  <= 1'b0;
            cmd_strobe_reg <= 1'b0;
            drop_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            inc_reg        <= inc_next;
            disp_reg       <= disp_next;
            clr_idx_reg    <= clr_idx_next;
            wr_strobe_reg  <= wr_strobe_next;
            cmd_strobe_reg <= cmd_strobe_next;
            drop_reg       <= drop_next;
        end
    end

    // Cells stay in flops: all 32 are visible in parallel on the row buses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                cell_reg[i] <= BLANK_CHAR;
            end
        end else if (cell_we) begin
            cell_reg[cell_idx] <= cell_val;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_pack
            assign row_1[127 - 8*gi -: 8] = cell_reg[gi];
            assign row_2[127 - 8*gi -: 8] = cell_reg[16 + gi];
        end
    endgenerate

    assign ddram_addr = addr_reg;
    assign display_on = disp_reg;
    assign busy       = (state_reg == ST_CLEAR);
    assign wr_strobe  = wr_strobe_reg;
    assign cmd_strobe = cmd_strobe_reg;
    assign drop       = drop_reg;

endmodule
